// File: rtl/delay_cap_pkg.sv
// delay_cap_pkg: shared FSM state type, default counter width and saturation helper for delay_capture_unit
package delay_cap_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_TRIG, WAIT_RISE, WAIT_FALL, REPORT} cap_state_t;
  localparam int DEFAULT_CNT_W = 16;
  function automatic longint unsigned sat_max(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction
endpackage

// File: rtl/delay_capture_unit_if.sv
// delay_capture_unit_if: trigger/delay_out observation bus plus measurement results
interface delay_capture_unit_if
  import delay_cap_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
);
  logic             arm;
  logic             trigger;
  logic             delay_out;
  logic             busy;
  logic             meas_valid;
  logic [CNT_W-1:0] meas_delay;
  logic [CNT_W-1:0] meas_width;
  logic             overflow;
  logic             timeout;
  modport master (
    output arm, trigger, delay_out,
    input  busy, meas_valid, meas_delay, meas_width, overflow, timeout
  );
  modport slave (
    input  arm, trigger, delay_out,
    output busy, meas_valid, meas_delay, meas_width, overflow, timeout
  );
endinterface

// File: rtl/edge_detect.sv
// edge_detect: registered one-bit edge detector producing same-cycle rise/fall flags
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);
  logic r_q;
  // previous-cycle copy of the input
  always_ff @(posedge clk) r_q <= reset ? 1'b0 : i_d;
  assign o_rise = i_d & ~r_q;
  assign o_fall = ~i_d & r_q;
endmodule

// File: rtl/delay_capture_unit.sv
// delay_capture_unit: measures trigger-to-rise delay and pulse width of delay_out; DELAY_CAP_TIMEOUT_EN adds a rise timeout
module delay_capture_unit
  import delay_cap_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic                 clk,
  input logic                 reset,
  delay_capture_unit_if.slave io_bus
);
  localparam logic [CNT_W-1:0] L_MAX = CNT_W'(sat_max(CNT_W));
  cap_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_delay;
  logic [CNT_W-1:0] r_width;
  logic             r_busy;
  logic             r_valid;
  logic             r_ovf;
  logic             r_to;
  logic             w_trig_rise;
  logic             w_unused_trig_fall;
  logic             w_dout_rise;
  logic             w_dout_fall;
  logic             w_sat;
  logic [CNT_W-1:0] w_inc;
  logic             w_to_hit;
  edge_detect u_trig (.clk(clk), .reset(reset), .i_d(io_bus.trigger), .o_rise(w_trig_rise), .o_fall(w_unused_trig_fall));
  edge_detect u_dout (.clk(clk), .reset(reset), .i_d(io_bus.delay_out), .o_rise(w_dout_rise), .o_fall(w_dout_fall));
  assign w_sat = r_cnt == L_MAX;
  assign w_inc = w_sat ? L_MAX : r_cnt + CNT_W'(1);
`ifdef DELAY_CAP_TIMEOUT_EN
  assign w_to_hit = int'(r_cnt) + 1 >= TIMEOUT_CYC;
`else
  localparam int L_UNUSED_TIMEOUT = TIMEOUT_CYC;
  assign w_to_hit = 1'b0;
`endif
  // measurement FSM: one shared counter times the delay phase, then the width phase
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_delay <= '0;
      r_width <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: if (io_bus.arm) begin
          r_state <= WAIT_TRIG;
          r_busy  <= 1'b1;
          r_cnt   <= '0;
          r_delay <= '0;
          r_width <= '0;
          r_ovf   <= 1'b0;
          r_to    <= 1'b0;
        end
        WAIT_TRIG: if (w_trig_rise) begin
          r_cnt   <= '0;
          r_state <= WAIT_RISE;
        end
        WAIT_RISE: begin
          r_cnt <= w_inc;
          r_ovf <= r_ovf | w_sat;
          if (w_dout_rise) begin
            r_delay <= w_inc;
            r_cnt   <= '0;
            r_state <= WAIT_FALL;
          end else if (w_to_hit) begin
            r_to    <= 1'b1;
            r_delay <= '1;
            r_width <= '0;
            r_valid <= 1'b1;
            r_state <= REPORT;
          end
        end
        WAIT_FALL: begin
          r_cnt <= w_inc;
          r_ovf <= r_ovf | w_sat;
          if (w_dout_fall) begin
            r_width <= w_inc;
            r_valid <= 1'b1;
            r_state <= REPORT;
          end
        end
        REPORT: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign io_bus.busy       = r_busy;
  assign io_bus.meas_valid = r_valid;
  assign io_bus.meas_delay = r_delay;
  assign io_bus.meas_width = r_width;
  assign io_bus.overflow   = r_ovf;
  assign io_bus.timeout    = r_to;
endmodule

// File: tb/tb_delay_capture_unit.sv
// tb_delay_capture_unit: directed stimulus with a scoreboard queue checked by a valid-driven monitor
module tb_delay_capture_unit;
  localparam int W = 4;
  typedef struct packed {
    logic [W-1:0] d;
    logic [W-1:0] w;
    logic         o;
    logic         t;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  exp_t exp_q[$];
  exp_t e;
  delay_capture_unit_if #(.CNT_W(W)) bus ();
  delay_capture_unit #(.CNT_W(W), .TIMEOUT_CYC(10)) dut (.clk(clk), .reset(reset), .io_bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  // monitor: every valid strobe must match the oldest expected result
  always @(negedge clk) begin
    if (!reset && bus.meas_valid) begin
      if (exp_q.size() == 0) chk("unexpected_valid", 32'(bus.meas_valid), 0);
      else begin
        e = exp_q.pop_front();
        chk("meas_delay", 32'(bus.meas_delay), 32'(e.d));
        chk("meas_width", 32'(bus.meas_width), 32'(e.w));
        chk("overflow", 32'(bus.overflow), 32'(e.o));
        chk("timeout", 32'(bus.timeout), 32'(e.t));
      end
    end
  end
  task automatic run(input logic pre, input int dly, input int wid, input logic retrig,
                     input logic [W-1:0] ed, input logic [W-1:0] ew, input logic eo);
    exp_q.push_back('{ed, ew, eo, 1'b0});
    bus.delay_out = pre;
    cyc(1);
    bus.arm = 1'b1;
    cyc(1);
    bus.arm = 1'b0;
    chk("busy_after_arm", 32'(bus.busy), 1);
    chk("ovf_cleared_on_arm", 32'(bus.overflow), 0);
    cyc(1);
    bus.delay_out = 1'b0;
    cyc(1);
    bus.trigger = 1'b1;
    cyc(1);
    bus.trigger = 1'b0;
    for (int i = 1; i < dly; i++) begin
      bus.trigger = retrig && i == 3;
      bus.arm = retrig && i == 4;
      cyc(1);
    end
    bus.trigger = 1'b0;
    bus.arm = 1'b0;
    bus.delay_out = 1'b1;
    cyc(wid);
    bus.delay_out = 1'b0;
    cyc(1);
    bus.arm = 1'b1;
    cyc(1);
    bus.arm = 1'b0;
    cyc(2);
    chk("busy_idle_after_report", 32'(bus.busy), 0);
    chk("delay_held", 32'(bus.meas_delay), 32'(ed));
  endtask
  initial begin
    bus.arm = 1'b0;
    bus.trigger = 1'b0;
    bus.delay_out = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_valid", 32'(bus.meas_valid), 0);
    chk("rst_delay", 32'(bus.meas_delay), 0);
    chk("rst_width", 32'(bus.meas_width), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    chk("rst_timeout", 32'(bus.timeout), 0);
    run(1'b0, 7, 3, 1'b0, 4'd7, 4'd3, 1'b0);
    run(1'b1, 5, 2, 1'b0, 4'd5, 4'd2, 1'b0);
    run(1'b0, 6, 2, 1'b1, 4'd6, 4'd2, 1'b0);
    run(1'b0, 20, 2, 1'b0, 4'd15, 4'd2, 1'b1);
    run(1'b0, 4, 1, 1'b0, 4'd4, 4'd1, 1'b0);
    bus.arm = 1'b1;
    cyc(1);
    bus.arm = 1'b0;
    cyc(1);
    bus.trigger = 1'b1;
    cyc(1);
    bus.trigger = 1'b0;
    cyc(2);
    bus.delay_out = 1'b1;
    cyc(2);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_delay", 32'(bus.meas_delay), 0);
    chk("midrst_width", 32'(bus.meas_width), 0);
    chk("midrst_valid", 32'(bus.meas_valid), 0);
    bus.delay_out = 1'b0;
    cyc(6);
    chk("midrst_stays_idle", 32'(bus.busy), 0);
`ifdef DELAY_CAP_TIMEOUT_EN
    exp_q.push_back('{4'hF, 4'd0, 1'b0, 1'b1});
    bus.arm = 1'b1;
    cyc(1);
    bus.arm = 1'b0;
    cyc(1);
    bus.trigger = 1'b1;
    cyc(1);
    bus.trigger = 1'b0;
    cyc(20);
    chk("timeout_busy_released", 32'(bus.busy), 0);
`endif
    cyc(2);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
